steep_timer: RTL

STEEP_TIMER -- requirements
Module: steep_timer

---
 rtl/steep_timer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/steep_timer.sv
// Steep (brew) timer: counts tick pulses into lit LEDs and paints a GRB pixel frame buffer.
// Latency: state/done update on the clock edge that samples a request; framebuf lags state by one cycle.
// Backpressure: none; all inputs are level-sampled every cycle, priority stop > start > pause > tick.
// Optional feature: define STEEP_TIMER_FLASH_EN to flash the DONE display on every tick.
module steep_timer #(
    parameter int          NUM_LEDS      = 16,
    parameter int          TICKS_PER_LED = 16,
    parameter logic [7:0]  LED_BRIGHT    = 8'd255
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    tick,
    input  logic                    sw_start,
    input  logic                    sw_stop,
    input  logic                    sw_pause,
    input  logic [6:0]              steep_leds,
    output logic [NUM_LEDS*24-1:0]  framebuf,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int SUB_W = (TICKS_PER_LED > 1) ? $clog2(TICKS_PER_LED) : 1;
    localparam int LED_W = $clog2(NUM_LEDS + 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_LED - 1);
    localparam logic [LED_W-1:0] LED_MAX = LED_W'(NUM_LEDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SUB_W-1:0]        r_sub_cnt, w_sub_nxt;
    logic [LED_W-1:0]        r_led_cnt, w_led_nxt;
    logic [LED_W-1:0]        r_target, w_target_nxt;
    logic                    r_done, w_done_nxt;
    logic [NUM_LEDS*24-1:0]  r_framebuf, w_framebuf;
    logic [LED_W-1:0]        w_target_clamp;
    logic [LED_W-1:0]        w_led_inc;
    logic                    w_lit;

`ifdef STEEP_TIMER_FLASH_EN
    logic                    r_flash, w_flash_nxt;
    assign w_lit = r_flash;
`else
    assign w_lit = 1'b1;
`endif

    // Zero or oversize brew lengths fall back to the full strip.
    assign w_target_clamp = (steep_leds == 7'd0 || steep_leds > 7'(NUM_LEDS)) ?
                            LED_MAX : steep_leds[LED_W-1:0];
    assign w_led_inc      = r_led_cnt + 1'b1;

    // Next-state: one prioritised action per cycle; lower-priority requests are dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_sub_nxt    = r_sub_cnt;
        w_led_nxt    = r_led_cnt;
        w_target_nxt = r_target;
        w_done_nxt   = 1'b0;
`ifdef STEEP_TIMER_FLASH_EN
        w_flash_nxt  = r_flash;
`endif
        if (sw_stop) begin
            w_state_nxt = S_IDLE;
            w_sub_nxt   = '0;
            w_led_nxt   = '0;
        end else if (sw_start) begin
            w_state_nxt  = S_RUN;
            w_sub_nxt    = '0;
            w_led_nxt    = '0;
            w_target_nxt = w_target_clamp;
        end else if (sw_pause) begin
            if (r_state == S_RUN)
                w_state_nxt = S_PAUSE;
            else if (r_state == S_PAUSE)
                w_state_nxt = S_RUN;
        end else if (tick) begin
            case (r_state)
                S_RUN: begin
                    if (r_sub_cnt == SUB_MAX) begin
                        w_sub_nxt = '0;
                        w_led_nxt = w_led_inc;
                        if (w_led_inc == r_target) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
`ifdef STEEP_TIMER_FLASH_EN
                            w_flash_nxt = 1'b1;
`endif
                        end
                    end else begin
                        w_sub_nxt = r_sub_cnt + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef STEEP_TIMER_FLASH_EN
                    w_flash_nxt = ~r_flash;
`endif
                end
                default: ;
            endcase
        end
    end

    // Paint the frame from the currently registered state; it is registered below, hence one cycle of lag.
    always_comb begin
        w_framebuf = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (r_state)
                S_RUN, S_PAUSE: begin
                    if (i < int'(r_target)) begin
                        if (i < int'(r_led_cnt)) begin
                            w_framebuf[24*i+16 +: 8] = LED_BRIGHT;
                        end else if (i == int'(r_led_cnt)) begin
                            w_framebuf[24*i +: 8] = LED_BRIGHT;
                            if (r_state == S_PAUSE)
                                w_framebuf[24*i+8 +: 8] = LED_BRIGHT;
                        end
                    end
                end
                S_DONE: begin
                    if (i < int'(r_target) && w_lit)
                        w_framebuf[24*i +: 24] = {3{LED_BRIGHT}};
                end
                default: ;
            endcase
        end
    end

    // State, counters, done pulse and frame buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_sub_cnt  <= '0;
            r_led_cnt  <= '0;
            r_target   <= LED_MAX;
            r_done     <= 1'b0;
            r_framebuf <= '0;
`ifdef STEEP_TIMER_FLASH_EN
            r_flash    <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_sub_cnt  <= w_sub_nxt;
            r_led_cnt  <= w_led_nxt;
            r_target   <= w_target_nxt;
            r_done     <= w_done_nxt;
            r_framebuf <= w_framebuf;
`ifdef STEEP_TIMER_FLASH_EN
            r_flash    <= w_flash_nxt;
`endif
        end
    end

    assign framebuf = r_framebuf;
    assign state    = r_state;
    assign done     = r_done;

endmodule
